comando_up_down: RTL

Button front-end that generates the UP/DOWN command levels consumed by the up/down Moore counter. It sits on the producer end of that interface and runs on the fast board clock. It synchronizes and debounces two active-low push-buttons and turns each confirmed press into a pending command. Each command is held until the consumer signals, through a sample strobe, that it has captured it.

---
 rtl/comando_up_down_pkg.sv | 16 +
 rtl/comando_up_down_filtro_tecla.sv | 135 +++++++++++++
 rtl/comando_up_down.sv | 73 +++++++
 3 files changed

// File: rtl/comando_up_down_pkg.sv
// Shared definitions for the comando_up_down button front-end:
// debounce state encoding and default timing constants.
package comando_up_down_pkg;

    typedef enum logic [1:0] {
        SOLTO        = 2'b00,
        FILTRA_PRESS = 2'b01,
        PRESSIONADO  = 2'b10,
        FILTRA_SOLTA = 2'b11
    } estado_t;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int REPEAT_DELAY_DEF    = 25000000;
    localparam int REPEAT_PERIOD_DEF   = 10000000;

endpackage

// File: rtl/comando_up_down_filtro_tecla.sv
// filtro_tecla: single-key front-end. 2-flop synchronizer, debounce FSM and,
// when AUTO_REPEAT_EN is defined, a hold counter generating auto-repeat events.
// o_evento is a combinational one-cycle pulse; the consumer registers it on the
// same edge on which the FSM commits the press.
module filtro_tecla
    import comando_up_down_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
)(
    input  logic clock_inicial,
    input  logic RESET,
    input  logic i_tecla_n,
    output logic o_evento
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    // Reject configurations the counters cannot honour.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_param_invalido
        $error("filtro_tecla: invalid DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
    end

    logic          r_sync1;
    logic          r_sync2;
    estado_t       r_estado;
    estado_t       w_estado_prox;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_prox;
    logic [CW-1:0] w_cnt_inc;
    logic          w_tecla_solta;
    logic          w_evento;

`ifdef AUTO_REPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_prox;
`endif

    // Synchronizer; idles high so the key reads as released out of reset.
    always_ff @(posedge clock_inicial) begin
        if (RESET) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_tecla_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tecla_solta = r_sync2;
    // Saturating increment: the counter never wraps while the key stays put.
    assign w_cnt_inc = (r_cnt == CW'(DEBOUNCE_CYCLES)) ? r_cnt : r_cnt + 1'b1;

    // Debounce state, filter counter and hold counter registers.
    always_ff @(posedge clock_inicial) begin
        if (RESET) begin
            r_estado <= SOLTO;
            r_cnt    <= '0;
`ifdef AUTO_REPEAT_EN
            r_hold   <= '0;
`endif
        end else begin
            r_estado <= w_estado_prox;
            r_cnt    <= w_cnt_prox;
`ifdef AUTO_REPEAT_EN
            r_hold   <= w_hold_prox;
`endif
        end
    end

    // Next-state logic; a press event fires on the edge that confirms it.
    always_comb begin
        w_estado_prox = r_estado;
        w_cnt_prox    = r_cnt;
        w_evento      = 1'b0;
`ifdef AUTO_REPEAT_EN
        w_hold_prox   = '0;
`endif
        case (r_estado)
            SOLTO: begin
                if (!w_tecla_solta) begin
                    w_estado_prox = FILTRA_PRESS;
                    w_cnt_prox    = '0;
                end
            end
            FILTRA_PRESS: begin
                if (w_tecla_solta) begin
                    w_estado_prox = SOLTO;
                end else begin
                    w_cnt_prox = w_cnt_inc;
                    if (w_cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
                        w_estado_prox = PRESSIONADO;
                        w_evento      = 1'b1;
                    end
                end
            end
            PRESSIONADO: begin
                if (w_tecla_solta) begin
                    w_estado_prox = FILTRA_SOLTA;
                    w_cnt_prox    = '0;
                end else begin
`ifdef AUTO_REPEAT_EN
                    // First repeat after REPEAT_DELAY; later ones restart the
                    // count so the next fires REPEAT_PERIOD cycles on.
                    if (r_hold == HW'(REPEAT_DELAY - 1)) begin
                        w_evento    = 1'b1;
                        w_hold_prox = HW'(REPEAT_DELAY - REPEAT_PERIOD);
                    end else begin
                        w_hold_prox = r_hold + 1'b1;
                    end
`endif
                end
            end
            FILTRA_SOLTA: begin
                if (!w_tecla_solta) begin
                    w_estado_prox = PRESSIONADO;
                end else begin
                    w_cnt_prox = w_cnt_inc;
                    if (w_cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
                        w_estado_prox = SOLTO;
                    end
                end
            end
            default: begin
                w_estado_prox = SOLTO;
                w_cnt_prox    = '0;
            end
        endcase
    end

    assign o_evento = w_evento;

endmodule

// File: rtl/comando_up_down.sv
// comando_up_down: debounced UP/DOWN command producer for the up/down counter.
// Each confirmed press sets a pending level held until the consumer's AMOSTRA
// strobe; a repeated event on an already pending command pulses SOBREPOSICAO.
// Optional feature: define AUTO_REPEAT_EN for hold-to-repeat events.
module comando_up_down
    import comando_up_down_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
)(
    input  logic clock_inicial,
    input  logic RESET,
    input  logic KEY_UP_N,
    input  logic KEY_DOWN_N,
    input  logic AMOSTRA,
    output logic UP,
    output logic DOWN,
    output logic SOBREPOSICAO
);

    logic w_ev_up;
    logic w_ev_down;
    logic r_pend_up;
    logic r_pend_down;
    logic r_sobrepos;
    logic w_coalesce;

    filtro_tecla #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_filtro_up (
        .clock_inicial (clock_inicial),
        .RESET         (RESET),
        .i_tecla_n     (KEY_UP_N),
        .o_evento      (w_ev_up)
    );

    filtro_tecla #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_filtro_down (
        .clock_inicial (clock_inicial),
        .RESET         (RESET),
        .i_tecla_n     (KEY_DOWN_N),
        .o_evento      (w_ev_down)
    );

    // An event is coalesced when its command is still pending and not being
    // sampled this cycle; a sampled command accepts the new event as fresh.
    assign w_coalesce = (w_ev_up   & r_pend_up   & ~AMOSTRA) |
                        (w_ev_down & r_pend_down & ~AMOSTRA);

    // Pending command levels and the coalescing pulse, registered together.
    always_ff @(posedge clock_inicial) begin
        if (RESET) begin
            r_pend_up   <= 1'b0;
            r_pend_down <= 1'b0;
            r_sobrepos  <= 1'b0;
        end else begin
            r_pend_up   <= w_ev_up   | (r_pend_up   & ~AMOSTRA);
            r_pend_down <= w_ev_down | (r_pend_down & ~AMOSTRA);
            r_sobrepos  <= w_coalesce;
        end
    end

    assign UP           = r_pend_up;
    assign DOWN         = r_pend_down;
    assign SOBREPOSICAO = r_sobrepos;

endmodule
